// File: rtl/cpu_memarb_if.sv
// Request/response bundle between the core's memory channels, the external bus and cpu_memarb.
// master: requesters plus memory stall input; slave: the arbiter itself.
interface cpu_memarb_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [NCH-1:0]        ch_req;
    logic [NCH-1:0]        ch_we;
    logic [NCH*ADDR_W-1:0] ch_addr;
    logic [NCH*DATA_W-1:0] ch_wdata;
    logic [NCH-1:0]        ch_ack;
    logic [NCH-1:0]        ch_err;
    logic [NCH-1:0]        ch_wait;
    logic [DATA_W-1:0]     ch_rdata;
    logic [ADDR_W-1:0]     addr_o;
    logic                  re_o;
    logic                  we_o;
    logic                  needWait_i;

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, needWait_i,
        input  ch_ack, ch_err, ch_wait, ch_rdata, addr_o, re_o, we_o
    );

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, needWait_i,
        output ch_ack, ch_err, ch_wait, ch_rdata, addr_o, re_o, we_o
    );
endinterface

// File: rtl/cpu_memarb.sv
// Registered NCH-channel arbiter onto a single external memory bus, with fixed-priority or
// round-robin selection, wait-state hold and an optional wait-state timeout.
module cpu_memarb #(
    parameter int NCH        = 2,
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int PRIO_RR    = 0,
    parameter int WAIT_LIMIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    cpu_memarb_if.slave      bus,
    inout  wire [DATA_W-1:0] data_io
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK, ERR} state_t;

    state_t              state;
    state_t              state_nx;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       winner;
    logic [ADDR_W-1:0]   addr_lat;
    logic                we_lat;
    logic [DATA_W-1:0]   wdata_lat;
    logic [DATA_W-1:0]   rdata;
    logic [CW-1:0]       wait_cnt;
    logic                limit_hit;
    logic                bus_re;
    logic                bus_we;
    logic [NCH-1:0]      gmask;
    logic [NCH-1:0]      ack_v;
    logic [NCH-1:0]      err_v;
    logic [NCH*ADDR_W-1:0] addr_sh;
    logic [NCH*DATA_W-1:0] wdata_sh;
    logic [NCH-1:0]        we_sh;

    function automatic logic [GW-1:0] pick_fixed(input logic [NCH-1:0] req);
        logic [NCH-1:0] sh;
        logic [GW-1:0]  sel;
        sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            sh = req >> i;
            if (sh[0]) sel = GW'(i);
        end
        return sel;
    endfunction

    // Scan downward so the candidate closest after 'last' is the one that sticks.
    function automatic logic [GW-1:0] pick_rr(input logic [NCH-1:0] req, input logic [GW-1:0] last);
        logic [NCH-1:0] sh;
        logic [GW-1:0]  sel;
        int             c;
        sel = '0;
        for (int k = NCH; k >= 1; k--) begin
            c  = (int'(last) + k) % NCH;
            sh = req >> c;
            if (sh[0]) sel = GW'(c);
        end
        return sel;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    always_comb begin
        winner    = (PRIO_RR != 0) ? pick_rr(bus.ch_req, last_grant) : pick_fixed(bus.ch_req);
        addr_sh   = bus.ch_addr >> (int'(winner) * ADDR_W);
        wdata_sh  = bus.ch_wdata >> (int'(winner) * DATA_W);
        we_sh     = bus.ch_we >> winner;
        limit_hit = (WAIT_LIMIT != 0) && (wait_cnt >= CW'(WAIT_LIMIT));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|bus.ch_req) state_nx = ACCESS;
            ACCESS: begin
                if (!bus.needWait_i) state_nx = ACK;
                else if (limit_hit)  state_nx = ERR;
            end
            ACK:     state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gmask       = NCH'(1) << grant;
        bus_re      = (state == ACCESS) && !we_lat;
        bus_we      = (state == ACCESS) && we_lat;
        ack_v       = (state == ACK) ? gmask : '0;
        err_v       = (state == ERR) ? gmask : '0;
        bus.ch_ack   = ack_v;
        bus.ch_err   = err_v;
        bus.ch_wait  = bus.ch_req & ~(ack_v | err_v);
        bus.ch_rdata = rdata;
        bus.addr_o   = addr_lat;
        bus.re_o     = bus_re;
        bus.we_o     = bus_we;
    end

    assign data_io = bus_we ? wdata_lat : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_RST;
            addr_lat   <= '0;
            we_lat     <= 1'b0;
            wdata_lat  <= '0;
            rdata      <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (|bus.ch_req) begin
                        grant      <= winner;
                        last_grant <= winner;
                        addr_lat   <= addr_sh[ADDR_W-1:0];
                        wdata_lat  <= wdata_sh[DATA_W-1:0];
                        we_lat     <= we_sh[0];
                    end
                end
                // Latched request drives the bus; channel inputs are ignored here.
                ACCESS: begin
                    if (!bus.needWait_i) begin
                        if (!we_lat) rdata <= data_io;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end
                ACK, ERR: wait_cnt <= '0;
                default:  wait_cnt <= '0;
            endcase
        end
    end
endmodule

// File: doc/cpu_memarb.md
# cpu_memarb

Parametrised, registered multi-channel memory bus arbiter for the CPU core. It is the successor to the combinational fetch/data bus mux and supports NCH requesters (channel 0 is instruction fetch, channel 1 is load/store, higher channels are DMA/debug). It selects fixed-priority or round-robin arbitration. It latches the winning request and holds the external bus stable across wait states. It also aborts an access that waits too long. It sits between the core's request ports and the single external 16-bit memory bus.

## Interface
- NCH, 2, number of requesting channels (1..8)
- ADDR_W, 24, address width
- DATA_W, 16, data width
- PRIO_RR, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- WAIT_LIMIT, 0, maximum consecutive cycles needWait_i may hold one access; 0 = unlimited
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- ch_req  in  NCH  per-channel request; held high until the matching ack or err
- ch_we  in  NCH  1 = write, 0 = read
- ch_addr  in  NCH*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W]
- ch_wdata  in  NCH*DATA_W  channel i write data, same packing
- ch_ack  out  NCH  one-cycle completion pulse for the granted channel
- ch_err  out  NCH  one-cycle timeout pulse, mutually exclusive with ch_ack
- ch_wait  out  NCH  ch_req & ~(ch_ack | ch_err), combinational
- ch_rdata  out  DATA_W  read data, valid in the ack cycle, held until the next read completes
- addr_o  out  ADDR_W  registered bus address
- re_o, we_o  out  1 each  registered bus read/write strobes, never both high
- data_io  inout  DATA_W  driven with latched wdata only while we_o=1, else high-Z
- needWait_i  in  1  bus stall; the access completes in the first ACCESS cycle it is low

## Operation
- FSM: IDLE -> ACCESS -> ACK/ERR -> IDLE.
- IDLE: if any ch_req is high, pick the winner g. Latch addr, we, wdata and g. Enter ACCESS. If no request, stay in IDLE with re_o=we_o=0.
- Fixed priority: lowest set index wins.
- Round-robin: search starts at last_grant+1, mod NCH. last_grant updates on every grant. Its reset value is NCH-1, so channel 0 wins first.
- ACCESS: addr_o, re_o=~we, we_o=we come from the latches. Channel input changes are ignored.
  - needWait_i=0: capture data_io into ch_rdata (reads only). Go to ACK.
  - needWait_i=1: increment wait_cnt. If WAIT_LIMIT≠0 and wait_cnt reaches WAIT_LIMIT, go to ERR.
- ACK: ch_ack[g]=1 for one cycle, bus strobes low, wait_cnt cleared. Next state is IDLE.
- ERR: ch_err[g]=1 for one cycle, bus strobes low, ch_rdata unchanged, wait_cnt cleared. Next state is IDLE.
- A request that drops before its ack is a protocol violation. The access still completes on the bus, and the ack is still issued.
- wait_cnt is sized clog2(WAIT_LIMIT+1) and saturates. It never wraps.
- Writes do not change ch_rdata.

## Timing
- Reset values: FSM IDLE, addr_o=0, re_o=0, we_o=0, data_io=Z, ch_ack=0, ch_err=0, ch_rdata=0, last_grant=NCH-1, wait_cnt=0.
- Request seen in IDLE at cycle 0: bus strobes high in cycle 1. With zero wait, ch_ack is high in cycle 2. The next grant's bus cycle is cycle 4.
- Each wait cycle adds one cycle of latency.
- Throughput: one access per 3 cycles plus wait cycles.
- With WAIT_LIMIT=L, ch_err asserts in cycle L+2 after the request when needWait_i is stuck high.
- A channel with req still high in its own ack cycle is treated as a new request in the following IDLE cycle.
- rst during ACCESS: the next edge drops strobes and returns to IDLE. No ack or err is issued, and data_io goes to Z.
- Requests arriving during ACCESS/ACK/ERR wait for IDLE. None is lost, because all reqs are held.

## Test plan
- Single read, NCH=2, ch1 addr 0x00ABCD, data_io=0x1234, needWait_i=0 -> re_o cycle 1, addr_o=0x00ABCD, ch_ack=2'b10 cycle 2, ch_rdata=0x1234.
- Write with 3 wait cycles, ch0 addr 0x000010, wdata 0xBEEF -> we_o and data_io=0xBEEF held for 4 cycles, ack in cycle 5, data_io Z afterwards, ch_rdata unchanged.
- Both channels held requesting, PRIO_RR=0 -> grants 0,0,0,... and ch1 is starved. With PRIO_RR=1 -> grants 0,1,0,1.
- WAIT_LIMIT=4, needWait_i stuck 1 -> ch_err[g] pulses in cycle 6 and no ack follows. The next request is served normally.
- rst asserted during the second wait cycle of a write -> re_o/we_o=0 and data_io=Z on the next edge, no ack/err, last_grant=NCH-1.
- NCH=4, PRIO_RR=1, all req high -> grant order 0,1,2,3,0. re_o and we_o are never both high.
